tensor_dma_mc: RTL and testbench

TENSOR_DMA_MC -- requirements
Module: tensor_dma_mc

---
 rtl/tensor_dma_mc.sv | 157 +++++++++++++++
 tb/tb_tensor_dma_mc.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tensor_dma_mc.sv
// tensor_dma_mc: multi-channel tensor DMA beat sequencer with round-robin channel grant.
// Optional abort support is compiled in with TENSOR_DMA_ABORT_EN.
module tensor_dma_mc #(
   parameter int DATAWIDTH = 8,
   parameter int NUM_CH = 4,
   parameter int FIFO_DELAY = 2,
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 write,
   input  logic [DATAWIDTH-1:0] data_in,
   input  logic [2:0]           select,
   input  logic [CW-1:0]        ch_sel,
   output logic [DATAWIDTH-1:0] address_out,
   output logic                 rW_out,
   output logic                 tensor_ren,
   output logic                 tensor_wen,
   output logic [DATAWIDTH-1:0] depth_out,
   output logic [DATAWIDTH-1:0] width_out,
   output logic [1:0]           set,
   output logic [CW-1:0]        active_ch,
   output logic [NUM_CH-1:0]    busy,
   output logic                 finished_transfer,
   output logic [CW-1:0]        done_ch,
   output logic                 error_out
);
   localparam int NW = 2 * DATAWIDTH;
   typedef enum logic [2:0] {IDLE, ARB, WAIT, TRANSFER, FINISH} state_t;
   state_t state, next;
   logic [DATAWIDTH-1:0] cols [NUM_CH];
   logic [DATAWIDTH-1:0] rows [NUM_CH];
   logic [DATAWIDTH-1:0] base [NUM_CH];
   logic [DATAWIDTH-1:0] stride [NUM_CH];
   logic [1:0] op_set [NUM_CH];
   logic [CW-1:0] rr, grant, idx;
   logic [NW-1:0] n, cnt, n_calc;
   logic [2:0] wcnt;
   logic [DATAWIDTH-1:0] addr, stride_eff;
   logic found, ch_ok, wr_ok, x2, last, abort_act, abort_pend;

   assign ch_ok = int'(ch_sel) < NUM_CH;
   // config of a busy channel is frozen; the done cycle still has busy set, so late writes drop too
   assign wr_ok = write && ch_ok && !busy[ch_sel];
   assign found = |busy;
   assign n_calc = NW'(cols[grant]) * NW'(rows[grant]);
   assign x2 = op_set[active_ch] == 2'd2;
   assign last = cnt == n - NW'(1);
   assign stride_eff = stride[active_ch] == '0 ? DATAWIDTH'(1) : stride[active_ch];
   assign address_out = addr;
   assign depth_out = cols[active_ch];
   assign width_out = rows[active_ch];
   assign set = op_set[active_ch];
   assign done_ch = active_ch;

`ifdef TENSOR_DMA_ABORT_EN
   logic err, abort_req, in_service;
   assign abort_req = write && select == 3'd3 && data_in[1] && ch_ok;
   assign in_service = state != IDLE && ch_sel == (state == ARB ? grant : active_ch);
   assign abort_act = abort_req && in_service && (state == WAIT || state == TRANSFER);
   assign abort_pend = abort_req && busy[ch_sel] && !in_service;
   assign error_out = finished_transfer && err;
   always_ff @(posedge clk)
      if (rst) err <= 1'b0;
      else if (abort_act) err <= 1'b1;
      else if (state == ARB) err <= 1'b0;
`else
   assign abort_act = 1'b0;
   assign abort_pend = 1'b0;
   assign error_out = 1'b0;
`endif

   // scan downward so the busy channel nearest after rr wins
   always_comb begin
      grant = rr;
      idx = rr;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = CW'((int'(rr) + i) % NUM_CH);
         if (busy[idx]) grant = idx;
      end
   end

   always_ff @(posedge clk) state <= rst ? IDLE : next;

   always_comb begin
      next = state;
      rW_out = 1'b0;
      tensor_ren = 1'b0;
      tensor_wen = 1'b0;
      finished_transfer = 1'b0;
      case (state)
         IDLE: next = found ? ARB : IDLE;
         ARB: next = !found ? IDLE : (n_calc == '0 ? FINISH : WAIT);
         WAIT: if (wcnt == 3'(FIFO_DELAY - 1)) begin
            next = TRANSFER;
            rW_out = x2;
            tensor_ren = x2;
         end
         TRANSFER: begin
            rW_out = x2 && !last;
            tensor_ren = x2 && !last;
            tensor_wen = !x2;
            next = last ? FINISH : TRANSFER;
         end
         FINISH: begin
            finished_transfer = 1'b1;
            next = IDLE;
         end
         default: next = IDLE;
      endcase
      if (abort_act) next = FINISH;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cols[i] <= '0;
            rows[i] <= '0;
            base[i] <= '0;
            stride[i] <= '0;
            op_set[i] <= '0;
         end
         busy <= '0;
         rr <= '0;
         active_ch <= '0;
         n <= '0;
         cnt <= '0;
         wcnt <= '0;
         addr <= '0;
      end else begin
         if (wr_ok)
            case (select)
               3'd0: cols[ch_sel] <= data_in;
               3'd1: rows[ch_sel] <= data_in;
               3'd2: op_set[ch_sel] <= data_in[1:0];
               3'd3: busy[ch_sel] <= data_in[0];
               3'd4: base[ch_sel] <= data_in;
               3'd5: stride[ch_sel] <= data_in;
               default: ;
            endcase
         if (state == FINISH) busy[active_ch] <= 1'b0;
         if (abort_pend) busy[ch_sel] <= 1'b0;
         if (state == ARB && found) begin
            active_ch <= grant;
            rr <= CW'((int'(grant) + 1) % NUM_CH);
            n <= n_calc;
            addr <= base[grant];
            cnt <= '0;
         end
         wcnt <= state == WAIT ? wcnt + 3'd1 : 3'd0;
         if (state == TRANSFER) begin
            cnt <= cnt + NW'(1);
            addr <= addr + stride_eff;
         end
      end
   end
endmodule

// File: tb/tb_tensor_dma_mc.sv
// tb_tensor_dma_mc: directed checks of tensor_dma_mc with hand-computed expectations.
module tb_tensor_dma_mc;
   logic clk = 0, rst = 1, write = 0;
   logic [7:0] data_in = 0;
   logic [2:0] select = 0;
   logic [1:0] ch_sel = 0;
   logic [7:0] address_out, depth_out, width_out;
   logic rW_out, tensor_ren, tensor_wen, finished_transfer, error_out;
   logic [1:0] set, active_ch, done_ch;
   logic [3:0] busy;
   int total = 0, bad = 0;
   logic [7:0] waddr[$], raddr[$];
   logic [7:0] all_addr [64];
   int first_w, first_r, done_cyc, rwm, nb, got, e;
   logic [1:0] dch;
   logic derr;
   logic [15:0] ord;

   tensor_dma_mc dut (
      .clk(clk), .rst(rst), .write(write), .data_in(data_in), .select(select), .ch_sel(ch_sel),
      .address_out(address_out), .rW_out(rW_out), .tensor_ren(tensor_ren), .tensor_wen(tensor_wen),
      .depth_out(depth_out), .width_out(width_out), .set(set), .active_ch(active_ch), .busy(busy),
      .finished_transfer(finished_transfer), .done_ch(done_ch), .error_out(error_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] c, input logic [2:0] s, input logic [7:0] d);
      ch_sel = c;
      select = s;
      data_in = d;
      write = 1;
      @(posedge clk);
      #1 write = 0;
   endtask

   // cycle 0 is the first cycle with the new busy bit visible
   task automatic cap(input int maxc);
      waddr.delete();
      raddr.delete();
      first_w = -1;
      first_r = -1;
      done_cyc = -1;
      rwm = 0;
      for (int i = 0; i < maxc && done_cyc < 0; i++) begin
         @(negedge clk);
         if (i < 64) all_addr[i] = address_out;
         if (rW_out !== tensor_ren) rwm++;
         if (tensor_wen) begin
            if (first_w < 0) first_w = i;
            waddr.push_back(address_out);
         end
         if (tensor_ren) begin
            if (first_r < 0) first_r = i;
            raddr.push_back(address_out);
         end
         if (finished_transfer) begin
            done_cyc = i;
            dch = done_ch;
            derr = error_out;
         end
      end
   endtask

   task automatic collect(input int n);
      ord = 0;
      got = 0;
      for (int i = 0; i < 200 && got < n; i++) begin
         @(negedge clk);
         if (finished_transfer) begin
            ord = {ord[11:0], 2'b00, done_ch};
            got++;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;
   endtask

   initial begin
      do_reset();
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_en", {rW_out, tensor_ren, tensor_wen}, 0);
      chk("rst_fin", {finished_transfer, error_out}, 0);
      chk("rst_addr", address_out, 0);
      chk("rst_ch", {active_ch, done_ch}, 0);
      // basic write transfer
      wr(0, 0, 2); wr(0, 1, 3); wr(0, 4, 8'h10); wr(0, 5, 1); wr(0, 3, 1);
      cap(40);
      e = 0;
      foreach (waddr[k]) if (waddr[k] !== 8'(8'h10 + k)) e++;
      chk("r19_first", first_w, 4);
      chk("r19_nbeats", waddr.size(), 6);
      chk("r19_addrs", e, 0);
      chk("r19_nren", raddr.size(), 0);
      chk("r19_done", done_cyc, 10);
      chk("r19_dch", dch, 0);
      chk("r19_err", derr, 0);
      chk("r19_dims", {depth_out, width_out}, 16'h0203);
      // pop with prefetch and address wrap
      wr(1, 0, 4); wr(1, 1, 1); wr(1, 2, 2); wr(1, 4, 8'hFE); wr(1, 5, 1);
      chk("r19_busy_clr", busy, 0);
      wr(1, 3, 1);
      cap(40);
      chk("r20_first_ren", first_r, 3);
      chk("r20_nren", raddr.size(), 4);
      chk("r20_nwen", waddr.size(), 0);
      chk("r20_rw", rwm, 0);
      chk("r20_a0", all_addr[4], 8'hFE);
      chk("r20_a1", all_addr[5], 8'hFF);
      chk("r20_a2", all_addr[6], 8'h00);
      chk("r20_a3", all_addr[7], 8'h01);
      chk("r20_done", done_cyc, 8);
      chk("r20_dch", dch, 1);
      chk("r20_cfg", {set, depth_out, width_out}, 18'h20401);
      // zero-size transfer
      wr(2, 3, 1);
      cap(20);
      chk("r22_done", done_cyc, 2);
      chk("r22_dch", dch, 2);
      chk("r22_noen", {first_w, first_r}, {32'hFFFFFFFF, 32'hFFFFFFFF});
      // round-robin ordering
      do_reset();
      wr(0, 0, 2); wr(0, 1, 1);
      wr(0, 3, 1); wr(2, 3, 1); wr(3, 3, 1);
      collect(3);
      chk("r21_order_a", ord, 16'h0023);
      wr(0, 3, 1); wr(2, 3, 1); wr(3, 3, 1);
      @(posedge clk); #1;
      wr(1, 3, 1);
      collect(4);
      chk("r21_order_b", ord, 16'h0123);
      // stride and reset mid-transfer
      wr(0, 0, 3); wr(0, 1, 1); wr(0, 4, 0); wr(0, 5, 3); wr(0, 3, 1);
      repeat (5) @(negedge clk);
      chk("r23_a0", {tensor_wen, address_out}, 9'h100);
      @(negedge clk);
      chk("r23_a1", {tensor_wen, address_out}, 9'h103);
      @(negedge clk);
      chk("r23_a2", {tensor_wen, address_out}, 9'h106);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("r23_rst_en", {rW_out, tensor_ren, tensor_wen, finished_transfer, error_out}, 0);
      chk("r23_rst_state", {busy, active_ch, done_ch}, 0);
      chk("r23_rst_data", {address_out, depth_out, width_out, set}, 0);
      e = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (finished_transfer) e++;
      end
      chk("r23_nodone", e, 0);
      // abort request on beat 2 of 8
      @(posedge clk); #1;
      wr(0, 0, 8); wr(0, 1, 1); wr(0, 4, 8'h20); wr(0, 5, 1); wr(0, 3, 1);
      nb = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (tensor_wen) nb++;
      end
      ch_sel = 0; select = 3; data_in = 8'h02; write = 1;
      @(posedge clk);
      #1 write = 0;
      cap(30);
      chk("r24_pre", nb, 3);
`ifdef TENSOR_DMA_ABORT_EN
      chk("r24_post", waddr.size(), 0);
      chk("r24_done", done_cyc, 0);
      chk("r24_err", derr, 1);
`else
      chk("r24_post", waddr.size(), 5);
      chk("r24_last", waddr[$], 8'h27);
      chk("r24_done", done_cyc, 5);
      chk("r24_err", derr, 0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
